// File: rtl/board_io_pkg.sv
// Shared register map, status bit positions and seven-segment table for the
// board I/O Wishbone slave.
package board_io_pkg;

  typedef enum logic [2:0] {
    REG_HEXVAL = 3'd0,
    REG_HEXCTL = 3'd1,
    REG_LEDR   = 3'd2,
    REG_INPUT  = 3'd3,
    REG_TCOUNT = 3'd4,
    REG_TCMP   = 3'd5,
    REG_ISTAT  = 3'd6,
    REG_IEN    = 3'd7
  } reg_sel_e;

  localparam int ISTAT_TMR = 0;
  localparam int ISTAT_KEY = 1;
  localparam int HEXCTL_EN = 6;

  localparam logic [31:0] TCMP_RST = 32'hFFFF_FFFF;

  // Active-low segments, bit0 = a .. bit6 = g.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/hex7seg_dec.sv
// One hex digit to active-low seven-segment pattern, with a blank override.
module hex7seg_dec
  import board_io_pkg::*;
(
  input  logic [3:0] i_val,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  assign o_seg = i_blank ? 7'h7F : SEG_TABLE[i_val];

endmodule

// File: rtl/wb_board_io.sv
// Wishbone classic slave for board switches, keys, LEDs, six hex digits and
// a free-running timer with compare interrupt.
module wb_board_io
  import board_io_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 10000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  input  logic [9:0]  sw_i,
  input  logic [3:0]  key_i,
  output logic [6:0]  hex0_o,
  output logic [6:0]  hex1_o,
  output logic [6:0]  hex2_o,
  output logic [6:0]  hex3_o,
  output logic [6:0]  hex4_o,
  output logic [6:0]  hex5_o,
  output logic [9:0]  ledr_o,
  output logic        irq_o
);

  localparam int TW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;

  logic        r_ack;
  logic [31:0] r_dat;
  logic [23:0] r_hexval;
  logic [6:0]  r_hexctl;
  logic [9:0]  r_ledr;
  logic [31:0] r_tcount;
  logic [31:0] r_tcmp;
  logic [1:0]  r_istat;
  logic [1:0]  r_ien;
  logic        r_irq;
  logic [13:0] r_sync1, r_sync2, r_samp, r_deb;
  logic [TW-1:0] r_tick_cnt;

  logic        w_req, w_wr, w_tick, w_key_rise, w_tcount_clr;
  reg_sel_e    w_reg;
  logic [31:0] w_mask, w_rdata;
  logic [13:0] w_stable;
  logic [1:0]  w_istat_set, w_istat_clr;
  logic [5:0]  w_blank;
  logic [6:0]  w_seg [6];
  logic        w_unused;

  assign w_unused = ^wb_adr_i[1:0];
  assign w_req    = wb_cyc_i & wb_stb_i & ~r_ack;
  assign w_wr     = w_req & wb_we_i;
  assign w_reg    = reg_sel_e'(wb_adr_i[4:2]);
  assign w_mask   = lane_mask(wb_sel_i);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hexval <= '0;
      r_hexctl <= '0;
      r_ledr   <= '0;
      r_tcmp   <= TCMP_RST;
      r_ien    <= '0;
    end else if (w_wr) begin
      case (w_reg)
        REG_HEXVAL: r_hexval <= (r_hexval & ~w_mask[23:0]) | (wb_dat_i[23:0] & w_mask[23:0]);
        REG_HEXCTL: r_hexctl <= (r_hexctl & ~w_mask[6:0]) | (wb_dat_i[6:0] & w_mask[6:0]);
        REG_LEDR:   r_ledr   <= (r_ledr & ~w_mask[9:0]) | (wb_dat_i[9:0] & w_mask[9:0]);
        REG_TCMP:   r_tcmp   <= (r_tcmp & ~w_mask) | (wb_dat_i & w_mask);
        REG_IEN:    r_ien    <= (r_ien & ~w_mask[1:0]) | (wb_dat_i[1:0] & w_mask[1:0]);
        default: ;
      endcase
    end
  end

  assign w_tcount_clr = w_wr && (w_reg == REG_TCOUNT) && (|wb_sel_i);

  always_ff @(posedge clk) begin
    if (reset || w_tcount_clr) r_tcount <= '0;
    else                       r_tcount <= r_tcount + 32'd1;
  end

  // Debounce sample tick: down-counter reloading on terminal count.
  assign w_tick = (r_tick_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset)       r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= TW'(DEBOUNCE_TICKS - 1);
    else             r_tick_cnt <= r_tick_cnt - 1'b1;
  end

  // Keys are inverted on entry so every synchronised bit is "active = 1".
  assign w_stable = ~(r_sync2 ^ r_samp);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_samp  <= '0;
      r_deb   <= '0;
    end else begin
      r_sync1 <= {~key_i, sw_i};
      r_sync2 <= r_sync1;
      if (w_tick) begin
        r_samp <= r_sync2;
        r_deb  <= (r_deb & ~w_stable) | (r_sync2 & w_stable);
      end
    end
  end

  assign w_key_rise = w_tick & (|(r_sync2[13:10] & w_stable[13:10] & ~r_deb[13:10]));

  always_comb begin
    w_istat_set = '0;
    w_istat_set[ISTAT_TMR] = (r_tcount == r_tcmp);
    w_istat_set[ISTAT_KEY] = w_key_rise;
  end

  assign w_istat_clr = (w_wr && (w_reg == REG_ISTAT)) ? (wb_dat_i[1:0] & w_mask[1:0]) : 2'b00;

  // Set is OR'd in after the clear so a coincident event is never lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_istat <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_istat <= (r_istat & ~w_istat_clr) | w_istat_set;
      r_irq   <= |(r_istat & r_ien);
    end
  end

  always_comb begin
    w_rdata = '0;
    case (w_reg)
      REG_HEXVAL: w_rdata[23:0] = r_hexval;
      REG_HEXCTL: w_rdata[6:0]  = r_hexctl;
      REG_LEDR:   w_rdata[9:0]  = r_ledr;
      REG_INPUT:  w_rdata[13:0] = r_deb;
      REG_TCOUNT: w_rdata       = r_tcount;
      REG_TCMP:   w_rdata       = r_tcmp;
      REG_ISTAT:  w_rdata[1:0]  = r_istat;
      REG_IEN:    w_rdata[1:0]  = r_ien;
      default:    w_rdata       = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_req;
      r_dat <= (w_req && !wb_we_i) ? w_rdata : '0;
    end
  end

  // Reset masks an ack already in flight so the master sees no completion.
  assign wb_ack_o = r_ack & ~reset;
  assign wb_dat_o = reset ? '0 : r_dat;
  assign irq_o    = r_irq;
  assign ledr_o   = r_ledr;

  assign w_blank = ~{6{r_hexctl[HEXCTL_EN]}} | r_hexctl[5:0];

  for (genvar g = 0; g < 6; g++) begin : g_dec
    hex7seg_dec u_dec (
      .i_val  (r_hexval[4*g +: 4]),
      .i_blank(w_blank[g]),
      .o_seg  (w_seg[g])
    );
  end

  assign hex0_o = w_seg[0];
  assign hex1_o = w_seg[1];
  assign hex2_o = w_seg[2];
  assign hex3_o = w_seg[3];
  assign hex4_o = w_seg[4];
  assign hex5_o = w_seg[5];

endmodule

// File: tb/tb_wb_board_io.sv
// Scoreboard bench for wb_board_io: bus accesses push expected read data,
// a negedge monitor pops and compares on every ack.
module tb_wb_board_io;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i, wb_cyc_i, wb_stb_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic [9:0]  sw_i;
  logic [3:0]  key_i;
  logic [6:0]  hex_o [6];
  logic [9:0]  ledr_o;
  logic        irq_o;

  always #5 clk = ~clk;

  wb_board_io #(.DEBOUNCE_TICKS(4)) dut (
    .clk(clk), .reset(reset),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
    .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .sw_i(sw_i), .key_i(key_i),
    .hex0_o(hex_o[0]), .hex1_o(hex_o[1]), .hex2_o(hex_o[2]),
    .hex3_o(hex_o[3]), .hex4_o(hex_o[4]), .hex5_o(hex_o[5]),
    .ledr_o(ledr_o), .irq_o(irq_o)
  );

  localparam logic [6:0] SEG_REF [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  int errors = 0;
  int checks = 0;
  int unsigned cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  typedef struct { logic chk; logic [31:0] dat; } exp_t;
  exp_t exp_q[$];

  // Reference model state
  logic [23:0] m_hexval;
  logic [6:0]  m_hexctl;
  logic [9:0]  m_ledr;
  logic [31:0] m_tcmp;
  logic [1:0]  m_ien, m_istat;
  logic [9:0]  m_sw;
  logic [3:0]  m_keyp;
  int unsigned t_base;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  task automatic model_reset();
    m_hexval = '0; m_hexctl = '0; m_ledr = '0; m_tcmp = 32'hFFFF_FFFF;
    m_ien = '0; m_istat = '0;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (sel[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] r, input int unsigned k);
    case (r)
      3'd0: return {8'h0, m_hexval};
      3'd1: return {25'h0, m_hexctl};
      3'd2: return {22'h0, m_ledr};
      3'd3: return {18'h0, m_keyp, m_sw};
      3'd4: return 32'(k - 1 - t_base);
      3'd5: return m_tcmp;
      3'd6: return {30'h0, m_istat};
      default: return {30'h0, m_ien};
    endcase
  endfunction

  task automatic model_write(input logic [2:0] r, input logic [31:0] d, input logic [3:0] sel,
                             input int unsigned k);
    logic [31:0] t;
    case (r)
      3'd0: begin t = merge({8'h0, m_hexval}, d, sel); m_hexval = t[23:0]; end
      3'd1: begin t = merge({25'h0, m_hexctl}, d, sel); m_hexctl = t[6:0]; end
      3'd2: begin t = merge({22'h0, m_ledr}, d, sel); m_ledr = t[9:0]; end
      3'd4: if (sel != 4'h0) t_base = k;
      3'd5: m_tcmp = merge(m_tcmp, d, sel);
      3'd6: if (sel[0]) m_istat = m_istat & ~d[1:0];
      3'd7: begin t = merge({30'h0, m_ien}, d, sel); m_ien = t[1:0]; end
      default: ;
    endcase
  endtask

  // Called at #1 after an edge; recognition happens on the next edge.
  task automatic wb_xfer(input logic [2:0] r, input logic we, input logic [31:0] d,
                         input logic [3:0] sel);
    exp_t e;
    int unsigned k;
    wb_adr_i = {r, 2'($urandom)};
    wb_dat_i = d; wb_sel_i = sel; wb_we_i = we;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(posedge clk); #1;
    k = cyc_cnt;
    e.chk = !we;
    e.dat = we ? 32'h0 : model_read(r, k);
    exp_q.push_back(e);
    if (we) model_write(r, d, sel, k);
    check("ack_latency", wb_ack_o, 1);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(posedge clk); #1;
    check("ack_seen", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_outputs();
    for (int n = 0; n < 6; n++) begin
      logic [6:0] e;
      e = (m_hexctl[6] && !m_hexctl[n]) ? SEG_REF[m_hexval[4*n +: 4]] : 7'h7F;
      check($sformatf("hex%0d", n), hex_o[n], e);
    end
    check("ledr", ledr_o, m_ledr);
  endtask

  task automatic wait_until(input int unsigned t);
    while (cyc_cnt < t) begin @(posedge clk); #1; end
  endtask

  // Monitor: compares read data on each ack, checks one-cycle width and idle zero.
  logic prev_ack = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (wb_ack_o) begin
      check("ack_width_prev", prev_ack, 0);
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_ack: got ack with data %h expected none", wb_dat_o);
      end else begin
        e = exp_q.pop_front();
        if (e.chk) check("rdata", wb_dat_o, e.dat);
      end
    end else begin
      check("dat_idle", wb_dat_o, 0);
    end
    prev_ack = wb_ack_o;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0]  r;
    logic        we;
    logic [31:0] d;
    logic [3:0]  sel;
    int unsigned k0, p, rise;
    logic        bounce [6];

    reset = 1'b1; wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
    wb_we_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    sw_i = '0; key_i = 4'hF;
    model_reset(); m_sw = '0; m_keyp = '0;
    repeat (3) @(posedge clk);
    #1;
    t_base = cyc_cnt;
    reset = 1'b0;

    // Reset state
    check("rst_ack", wb_ack_o, 0);
    check("rst_irq", irq_o, 0);
    check_outputs();
    for (int i = 0; i < 8; i++) wb_xfer(3'(i), 1'b0, 32'h0, 4'hF);

    // Hex digits with partial lane write
    wb_xfer(3'd0, 1'b1, 32'hFFFF_FFFF, 4'hF);
    wb_xfer(3'd0, 1'b1, 32'h0000_A5F3, 4'b0111);
    wb_xfer(3'd1, 1'b1, 32'h0000_0040, 4'hF);
    check("hex0_3", hex_o[0], 7'h30);
    check("hex1_F", hex_o[1], 7'h0E);
    check("hex2_5", hex_o[2], 7'h12);
    check("hex3_A", hex_o[3], 7'h08);
    check("hex4_0", hex_o[4], 7'h40);
    check("hex5_0", hex_o[5], 7'h40);
    check_outputs();

    // LED byte lanes
    wb_xfer(3'd2, 1'b1, 32'h0000_03FF, 4'b0001);
    check("ledr_lane0", ledr_o, 10'h0FF);
    wb_xfer(3'd2, 1'b1, 32'h0000_03FF, 4'b0010);
    check("ledr_lane1", ledr_o, 10'h3FF);

    // Strobe without cycle is not a transfer
    wb_adr_i = {3'd2, 2'b00}; wb_dat_i = '0; wb_sel_i = 4'hF; wb_we_i = 1'b1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b1;
    @(posedge clk); #1;
    check("abort_ack", wb_ack_o, 0);
    check("abort_ledr", ledr_o, 10'h3FF);
    wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(posedge clk); #1;

    // Randomized register traffic
    for (int it = 0; it < 300; it++) begin
      if (it % 60 == 0) begin
        sw_i = 10'($urandom);
        m_sw = sw_i;
        repeat (20) @(posedge clk);
        #1;
      end
      r = 3'($urandom_range(0, 7));
      we = 1'($urandom);
      d = $urandom;
      sel = 4'($urandom);
      if (r == 3'd5) d[31] = 1'b1;
      wb_xfer(r, we, d, sel);
      check_outputs();
      check("irq_rand", irq_o, |(m_istat & m_ien));
    end

    // Timer compare interrupt, then W1C coinciding with the next match
    wb_xfer(3'd5, 1'b1, 32'd20, 4'hF);
    wb_xfer(3'd6, 1'b1, 32'h3, 4'hF);
    wb_xfer(3'd7, 1'b1, 32'h1, 4'hF);
    wb_xfer(3'd4, 1'b1, $urandom, 4'b1000);
    k0 = t_base;
    wait_until(k0 + 21);
    check("irq_before_lag", irq_o, 0);
    wait_until(k0 + 22);
    check("irq_after_match", irq_o, 1);
    m_istat[0] = 1'b1;
    wb_xfer(3'd6, 1'b0, 32'h0, 4'hF);
    wb_xfer(3'd4, 1'b1, $urandom, 4'hF);
    k0 = t_base;
    wait_until(k0 + 20);
    wb_xfer(3'd6, 1'b1, 32'h1, 4'h1);
    m_istat[0] = 1'b1;
    wb_xfer(3'd6, 1'b0, 32'h0, 4'hF);
    check("irq_set_wins", irq_o, 1);
    wb_xfer(3'd6, 1'b1, 32'h1, 4'h1);
    wb_xfer(3'd6, 1'b0, 32'h0, 4'hF);
    wb_xfer(3'd5, 1'b1, 32'hFFFF_FFFF, 4'hF);
    check("irq_cleared", irq_o, 0);

    // Key bounce then steady press
    wb_xfer(3'd6, 1'b1, 32'h3, 4'h1);
    wb_xfer(3'd7, 1'b1, 32'h2, 4'h1);
    repeat (4) @(posedge clk);
    #1;
    check("irq_key_idle", irq_o, 0);
    bounce = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    p = cyc_cnt;
    rise = 0;
    for (int i = 0; i < 40; i++) begin
      key_i[2] = (i < 6) ? bounce[i] : 1'b0;
      @(posedge clk); #1;
      if (irq_o && rise == 0) rise = cyc_cnt;
    end
    checks++;
    if (rise < p + 8 || rise > p + 17) begin
      errors++;
      $display("FAIL key_irq_timing: got rise at %0d expected between %0d and %0d", rise, p + 8, p + 17);
    end
    m_keyp[2] = 1'b1;
    m_istat[1] = 1'b1;
    wb_xfer(3'd3, 1'b0, 32'h0, 4'hF);
    wb_xfer(3'd6, 1'b0, 32'h0, 4'hF);
    wb_xfer(3'd6, 1'b1, 32'h2, 4'h1);
    repeat (12) @(posedge clk);
    #1;
    check("key_once", irq_o, 0);
    key_i = 4'hF;
    repeat (20) @(posedge clk);
    #1;
    m_keyp = '0;
    wb_xfer(3'd3, 1'b0, 32'h0, 4'hF);
    wb_xfer(3'd6, 1'b0, 32'h0, 4'hF);

    // Reset right after a recognised read
    wb_adr_i = {3'd5, 2'b00}; wb_we_i = 1'b0; wb_sel_i = 4'hF;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(posedge clk); #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_ack_suppress", wb_ack_o, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    t_base = cyc_cnt;
    model_reset();
    check("rst2_ack", wb_ack_o, 0);
    check("rst2_dat", wb_dat_o, 0);
    check("rst2_irq", irq_o, 0);
    check_outputs();
    wb_xfer(3'd5, 1'b0, 32'h0, 4'hF);
    wb_xfer(3'd1, 1'b0, 32'h0, 4'hF);
    wb_xfer(3'd4, 1'b0, 32'h0, 4'hF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
